// File: rtl/rgbled_chain_if.sv
// rtl/rgbled_chain_if.sv - host-side bus of the RGB LED chain driver
// Purpose: groups the colour-write handshake, the frame-update request, the status flag
//          and the serial LED data line into one bundle.
// Signals:
//   wr_valid_i   host -> ctrl  colour write request
//   wr_ready_o   ctrl -> host  write accepted when valid & ready (low while busy)
//   wr_idx_i     host -> ctrl  LED index, 0 = first LED on the wire
//   wr_rgb_i     host -> ctrl  colour {R,G,B}
//   update_req_i host -> ctrl  single-cycle pulse: transmit buffer to chain
//   busy_o       ctrl -> host  frame (including latch time) in progress or pending
//   rgbled_o     ctrl -> chain registered serial data
interface rgbled_chain_if #(
    parameter int IdxW = 1
);
    logic            wr_valid_i;
    logic            wr_ready_o;
    logic [IdxW-1:0] wr_idx_i;
    logic [23:0]     wr_rgb_i;
    logic            update_req_i;
    logic            busy_o;
    logic            rgbled_o;

    modport master (
        output wr_valid_i, wr_idx_i, wr_rgb_i, update_req_i,
        input  wr_ready_o, busy_o, rgbled_o
    );

    modport slave (
        input  wr_valid_i, wr_idx_i, wr_rgb_i, update_req_i,
        output wr_ready_o, busy_o, rgbled_o
    );
endinterface

// File: rtl/rgbled_chain_ctrl.sv
// rtl/rgbled_chain_ctrl.sv - WS2812-style daisy-chain RGB LED driver with colour buffer
// Purpose: holds NumLeds 24-bit colours written by the host and, on an update request,
//          serialises them onto one data pin (LED0 first, G/R/B each MSB first), followed
//          by a low latch period. Requests arriving during a frame collapse into one
//          follow-up frame.
// Ports:
//   clk_i  system clock
//   rst_i  asynchronous, active-high reset
//   bus    rgbled_chain_if slave: write handshake, update request, busy, serial output
module rgbled_chain_ctrl #(
    parameter int NumLeds   = 2,
    parameter int ClkFreqHz = 50_000_000,
    parameter int ResetUs   = 60,
    localparam int IdxW     = (NumLeds > 1) ? $clog2(NumLeds) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    rgbled_chain_if.slave bus
);
    localparam int BitCyc   = ClkFreqHz / 800_000;
    localparam int T0HCyc   = ClkFreqHz / 2_500_000;
    localparam int T1HCyc   = ClkFreqHz / 1_250_000;
    localparam int LatchCyc = ClkFreqHz / 1_000_000 * ResetUs;
    localparam int CntMax   = (BitCyc > LatchCyc) ? BitCyc : LatchCyc;
    localparam int CntW     = $clog2(CntMax + 1);

    localparam logic [CntW-1:0] BitLast   = CntW'(BitCyc - 1);
    localparam logic [CntW-1:0] LatchLast = CntW'(LatchCyc - 1);
    localparam logic [CntW-1:0] T0H       = CntW'(T0HCyc);
    localparam logic [CntW-1:0] T1H       = CntW'(T1HCyc);
    localparam logic [IdxW-1:0] LedLast   = IdxW'(NumLeds - 1);
    localparam logic [IdxW:0]   LedCount  = (IdxW + 1)'(NumLeds);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        LATCH = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [CntW-1:0] cnt, cnt_n;
    logic [4:0]      bit_idx, bit_n;
    logic [IdxW-1:0] led_idx, led_n;
    logic            pending, pending_n;
    logic [23:0]     color_mem [NumLeds];
    logic            led_q, led_out_n;
    logic            busy, wr_fire, wr_idx_ok;
    logic [23:0]     wire_word;
    logic            cur_bit;
    logic [CntW-1:0] high_cyc;

    assign busy           = (state != IDLE);
    assign bus.busy_o     = busy;
    assign bus.wr_ready_o = !busy;
    assign bus.rgbled_o   = led_q;
    assign wr_fire        = bus.wr_valid_i && !busy;
    assign wr_idx_ok      = ({1'b0, bus.wr_idx_i} < LedCount);

    // Buffer only changes while idle, so a frame always sees a stable snapshot.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumLeds; i++) color_mem[i] <= '0;
        end else if (wr_fire && wr_idx_ok) begin
            color_mem[bus.wr_idx_i] <= bus.wr_rgb_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            led_idx <= '0;
            pending <= 1'b0;
            led_q   <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_n;
            led_idx <= led_n;
            pending <= pending_n;
            led_q   <= led_out_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_n     = bit_idx;
        led_n     = led_idx;
        pending_n = pending;
        case (state)
            IDLE: begin
                if (bus.update_req_i) begin
                    state_n = SEND;
                    cnt_n   = '0;
                    bit_n   = '0;
                    led_n   = '0;
                end
            end
            SEND: begin
                if (bus.update_req_i) pending_n = 1'b1;
                if (cnt == BitLast) begin
                    cnt_n = '0;
                    if (bit_idx == 5'd23) begin
                        bit_n = '0;
                        if (led_idx == LedLast) begin
                            state_n = LATCH;
                            led_n   = '0;
                        end else begin
                            led_n = led_idx + 1'b1;
                        end
                    end else begin
                        bit_n = bit_idx + 5'd1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            LATCH: begin
                if (cnt == LatchLast) begin
                    cnt_n = '0;
                    // A request landing in the final latch cycle still counts as pending.
                    if (pending || bus.update_req_i) begin
                        state_n   = SEND;
                        pending_n = 1'b0;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                    if (bus.update_req_i) pending_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // The output flop is loaded with the level for the *next* cycle. On the first cycle of
    // any bit cnt_n is 0, which is high for both symbols, so a same-cycle buffer write that
    // is not yet visible here cannot affect the output.
    assign wire_word = {color_mem[led_n][15:8], color_mem[led_n][23:16], color_mem[led_n][7:0]};
    assign cur_bit   = wire_word[5'd23 - bit_n];
    assign high_cyc  = cur_bit ? T1H : T0H;
    assign led_out_n = (state_n == SEND) && (cnt_n < high_cyc);
endmodule
